// File: rtl/or4_resp_checker_pkg.sv
// Shared definitions for the OR4 response checker: FSM encodings and
// default sizing used by the interface, the top level and the bench.
package or4_chk_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_ARMED   = 3'd1,
    ST_SETTLE  = 3'd2,
    ST_COMPARE = 3'd3,
    ST_DONE    = 3'd4
  } state_t;

  localparam int SETTLE_CYCLES_DEF = 2;
  localparam int NUM_VECS_DEF      = 16;
  localparam int CNT_W_DEF         = 8;

  function automatic logic or4_expect(input logic [3:0] vec);
    return |vec;
  endfunction

endpackage

// File: rtl/or4_resp_checker_if.sv
// Stimulus/response bundle between the checker and whatever drives it.
// master drives stimulus and the DUT response; slave is the checker.
interface or4_resp_checker_if import or4_chk_pkg::*; #(
  parameter int CNT_W = CNT_W_DEF
);
  logic             i_start;
  logic             i_vec_valid;
  logic             i_a;
  logic             i_b;
  logic             i_c;
  logic             i_d;
  logic             i_f;
  logic             o_busy;
  logic             o_done;
  logic [CNT_W-1:0] o_pass_cnt;
  logic [CNT_W-1:0] o_fail_cnt;
  logic [3:0]       o_first_fail_vec;
  logic             o_fail_seen;
  logic             o_proto_err;

  modport master (
    output i_start, i_vec_valid, i_a, i_b, i_c, i_d, i_f,
    input  o_busy, o_done, o_pass_cnt, o_fail_cnt, o_first_fail_vec,
           o_fail_seen, o_proto_err
  );

  modport slave (
    input  i_start, i_vec_valid, i_a, i_b, i_c, i_d, i_f,
    output o_busy, o_done, o_pass_cnt, o_fail_cnt, o_first_fail_vec,
           o_fail_seen, o_proto_err
  );
endinterface

// File: rtl/or4_resp_checker_sat_counter.sv
// Saturating up-counter with synchronous clear; holds at all-ones.
module sat_counter #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clr,
  input  logic         inc,
  output logic [W-1:0] count
);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (inc && (count != {W{1'b1}})) begin
      count <= count + 1'b1;
    end
  end

endmodule

// File: rtl/or4_resp_checker.sv
// Checks an external OR4 gate: captures a vector, waits for it to settle,
// compares the returned bit against the OR of the vector and tallies results.
//
// state      | meaning
// -----------+-----------------------------------------------
// ST_IDLE    | after reset, waiting for the first start pulse
// ST_ARMED   | run active, waiting for the next vector
// ST_SETTLE  | vector applied, settle timer counting down
// ST_COMPARE | sampling i_f against the expected value
// ST_DONE    | all vectors compared, results held
module or4_resp_checker import or4_chk_pkg::*; #(
  parameter int SETTLE_CYCLES = SETTLE_CYCLES_DEF,
  parameter int NUM_VECS      = NUM_VECS_DEF,
  parameter int CNT_W         = CNT_W_DEF
) (
  input logic                i_clk,
  input logic                i_rst_n,
  or4_resp_checker_if.slave  bus
);

  localparam logic [3:0] SETTLE_LD = 4'(SETTLE_CYCLES);
  localparam logic [7:0] LAST_VEC  = 8'(NUM_VECS - 1);

  state_t     state;
  state_t     state_nxt;
  logic [3:0] settle_cnt;
  logic [3:0] vec_q;
  logic [7:0] vec_cnt;
  logic       capture;
  logic       stray;
  logic       compare;
  logic       match;

  assign match   = (bus.i_f == or4_expect(vec_q));
  assign compare = (state == ST_COMPARE) && !bus.i_start;

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Start outranks everything, including a coincident vec_valid.
  always_comb begin
    state_nxt = state;
    capture   = 1'b0;
    stray     = 1'b0;
    if (bus.i_start) begin
      state_nxt = ST_ARMED;
    end else begin
      case (state)
        ST_IDLE:    stray = bus.i_vec_valid;
        ST_ARMED: begin
          if (bus.i_vec_valid) begin
            capture   = 1'b1;
            state_nxt = ST_SETTLE;
          end
        end
        ST_SETTLE: begin
          stray = bus.i_vec_valid;
          if (settle_cnt <= 4'd1) begin
            state_nxt = ST_COMPARE;
          end
        end
        ST_COMPARE: begin
          stray     = bus.i_vec_valid;
          state_nxt = (vec_cnt == LAST_VEC) ? ST_DONE : ST_ARMED;
        end
        ST_DONE:    stray = bus.i_vec_valid;
        default:    state_nxt = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n || bus.i_start) begin
      settle_cnt           <= '0;
      vec_q                <= '0;
      vec_cnt              <= '0;
      bus.o_first_fail_vec <= '0;
      bus.o_fail_seen      <= 1'b0;
      bus.o_proto_err      <= 1'b0;
    end else begin
      if (capture) begin
        vec_q      <= {bus.i_a, bus.i_b, bus.i_c, bus.i_d};
        settle_cnt <= SETTLE_LD;
      end else if (state == ST_SETTLE) begin
        settle_cnt <= settle_cnt - 4'd1;
      end
      if (stray) begin
        bus.o_proto_err <= 1'b1;
      end
      if (compare) begin
        vec_cnt <= vec_cnt + 8'd1;
        if (!match && !bus.o_fail_seen) begin
          bus.o_first_fail_vec <= vec_q;
          bus.o_fail_seen      <= 1'b1;
        end
      end
    end
  end

  sat_counter #(.W(CNT_W)) u_pass_cnt (
    .clk   (i_clk),
    .rst_n (i_rst_n),
    .clr   (bus.i_start),
    .inc   (compare && match),
    .count (bus.o_pass_cnt)
  );

  sat_counter #(.W(CNT_W)) u_fail_cnt (
    .clk   (i_clk),
    .rst_n (i_rst_n),
    .clr   (bus.i_start),
    .inc   (compare && !match),
    .count (bus.o_fail_cnt)
  );

  assign bus.o_busy = (state == ST_ARMED) || (state == ST_SETTLE) ||
                      (state == ST_COMPARE);
  assign bus.o_done = (state == ST_DONE);

endmodule

// File: tb/tb_or4_resp_checker.sv
// Scoreboard bench for or4_resp_checker: two instances with different sizing,
// expected end-of-run results queued per run and checked when done rises.
module tb_or4_resp_checker;
  import or4_chk_pkg::*;

  localparam int S0 = 2, N0 = 16, W0 = 8;
  localparam int S1 = 1, N1 = 4,  W1 = 2;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n0, rst_n1;

  or4_resp_checker_if #(.CNT_W(W0)) bus0 ();
  or4_resp_checker_if #(.CNT_W(W1)) bus1 ();

  or4_resp_checker #(.SETTLE_CYCLES(S0), .NUM_VECS(N0), .CNT_W(W0)) dut0 (
    .i_clk(clk), .i_rst_n(rst_n0), .bus(bus0.slave));
  or4_resp_checker #(.SETTLE_CYCLES(S1), .NUM_VECS(N1), .CNT_W(W1)) dut1 (
    .i_clk(clk), .i_rst_n(rst_n1), .bus(bus1.slave));

  typedef struct {
    int         sel;
    int         pass_cnt;
    int         fail_cnt;
    logic [3:0] ffv;
    logic       fail_seen;
    logic       proto_err;
  } exp_t;

  exp_t sb_q[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic push_exp(input int sel, input int p, input int f,
                          input logic [3:0] ffv, input logic fs, input logic pe);
    exp_t e;
    e.sel = sel; e.pass_cnt = p; e.fail_cnt = f;
    e.ffv = ffv; e.fail_seen = fs; e.proto_err = pe;
    sb_q.push_back(e);
  endtask

  task automatic drive(input int sel, input logic start, input logic valid,
                       input logic [3:0] v, input logic f);
    if (sel == 0) begin
      bus0.i_start = start; bus0.i_vec_valid = valid;
      {bus0.i_a, bus0.i_b, bus0.i_c, bus0.i_d} = v; bus0.i_f = f;
    end else begin
      bus1.i_start = start; bus1.i_vec_valid = valid;
      {bus1.i_a, bus1.i_b, bus1.i_c, bus1.i_d} = v; bus1.i_f = f;
    end
  endtask

  task automatic pulse_start(input int sel, input logic with_valid);
    @(negedge clk); drive(sel, 1'b1, with_valid, 4'b1111, 1'b0);
    @(negedge clk); drive(sel, 1'b0, 1'b0, 4'b0000, 1'b0);
  endtask

  // f_cmp is on i_f only for the single cycle ending at the compare edge;
  // the inverse is driven around it, so a mistimed sample shows up in the counts.
  task automatic apply_vec(input int sel, input logic [3:0] v, input logic f_cmp,
                           input bit stray);
    int s;
    s = (sel == 0) ? S0 : S1;
    for (int j = 0; j <= s + 1; j++) begin
      @(negedge clk);
      drive(sel, 1'b0, (j == 0) || ((j == 1) && stray), v,
            (j == s + 1) ? f_cmp : ~f_cmp);
    end
  endtask

  // fmode: 0 good gate, 1 stuck at 0, 2 stuck at 1
  function automatic logic f_of(input logic [3:0] v, input int fmode);
    if (fmode == 1) return 1'b0;
    if (fmode == 2) return 1'b1;
    return |v;
  endfunction

  task automatic run_range(input int sel, input int n, input int fmode, input int stray_at);
    logic [3:0] v;
    for (int i = 0; i < n; i++) begin
      v = 4'(i);
      apply_vec(sel, v, f_of(v, fmode), i == stray_at);
    end
  endtask

  task automatic check_result(input int sel);
    exp_t e;
    int p, f, ffv, fs, pe;
    if (sb_q.size() == 0) begin
      n_cmp++; n_bad++;
      $display("FAIL sb_unexpected_done: got done on dut%0d expected no run pending", sel);
      return;
    end
    e = sb_q.pop_front();
    if (sel == 0) begin
      p = int'(bus0.o_pass_cnt); f = int'(bus0.o_fail_cnt);
      ffv = int'(bus0.o_first_fail_vec); fs = int'(bus0.o_fail_seen); pe = int'(bus0.o_proto_err);
    end else begin
      p = int'(bus1.o_pass_cnt); f = int'(bus1.o_fail_cnt);
      ffv = int'(bus1.o_first_fail_vec); fs = int'(bus1.o_fail_seen); pe = int'(bus1.o_proto_err);
    end
    chk("sb_dut_sel", sel, e.sel);
    chk("sb_pass_cnt", p, e.pass_cnt);
    chk("sb_fail_cnt", f, e.fail_cnt);
    chk("sb_first_fail_vec", ffv, int'(e.ffv));
    chk("sb_fail_seen", fs, int'(e.fail_seen));
    chk("sb_proto_err", pe, int'(e.proto_err));
  endtask

  logic done0_q = 1'b0, done1_q = 1'b0;
  initial begin
    forever begin
      @(negedge clk);
      if (bus0.o_done === 1'b1 && !done0_q) check_result(0);
      if (bus1.o_done === 1'b1 && !done1_q) check_result(1);
      done0_q = (bus0.o_done === 1'b1);
      done1_q = (bus1.o_done === 1'b1);
    end
  end

  task automatic chk_all_zero(input string tag);
    chk({tag, "_busy"}, int'(bus0.o_busy), 0);
    chk({tag, "_done"}, int'(bus0.o_done), 0);
    chk({tag, "_pass"}, int'(bus0.o_pass_cnt), 0);
    chk({tag, "_fail"}, int'(bus0.o_fail_cnt), 0);
    chk({tag, "_ffv"}, int'(bus0.o_first_fail_vec), 0);
    chk({tag, "_fail_seen"}, int'(bus0.o_fail_seen), 0);
    chk({tag, "_proto_err"}, int'(bus0.o_proto_err), 0);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: got no completion expected finish before time limit");
    $fatal(1);
  end

  initial begin
    drive(0, 1'b0, 1'b0, 4'b0000, 1'b0);
    drive(1, 1'b0, 1'b0, 4'b0000, 1'b0);
    rst_n0 = 1'b0; rst_n1 = 1'b0;
    repeat (3) @(negedge clk);
    chk_all_zero("reset");
    rst_n0 = 1'b1; rst_n1 = 1'b1;

    // vec_valid while idle is a protocol error; start clears it
    @(negedge clk); drive(1, 1'b0, 1'b1, 4'b1010, 1'b0);
    @(negedge clk); drive(1, 1'b0, 1'b0, 4'b0000, 1'b0);
    chk("idle_proto_err", int'(bus1.o_proto_err), 1);
    pulse_start(1, 1'b0);
    chk("start_clears_proto", int'(bus1.o_proto_err), 0);
    chk("start_busy", int'(bus1.o_busy), 1);

    // dut1 was just started; finish its run: stuck-at-0 on 0000,0010,0100,1000
    push_exp(1, 1, 3, 4'b0010, 1'b1, 1'b0);
    apply_vec(1, 4'b0000, 1'b0, 1'b0);
    apply_vec(1, 4'b0010, 1'b0, 1'b0);
    apply_vec(1, 4'b0100, 1'b0, 1'b0);
    apply_vec(1, 4'b1000, 1'b0, 1'b0);
    repeat (3) @(negedge clk);
    chk("dut1_done_held", int'(bus1.o_done), 1);
    chk("dut1_busy_done", int'(bus1.o_busy), 0);

    // four passing vectors on a 2-bit counter saturate at 3
    push_exp(1, 3, 0, 4'b0000, 1'b0, 1'b0);
    pulse_start(1, 1'b0);
    apply_vec(1, 4'b0001, 1'b1, 1'b0);
    apply_vec(1, 4'b0011, 1'b1, 1'b0);
    apply_vec(1, 4'b0111, 1'b1, 1'b0);
    apply_vec(1, 4'b1111, 1'b1, 1'b0);
    repeat (3) @(negedge clk);

    // good gate, all 16 vectors
    push_exp(0, 16, 0, 4'b0000, 1'b0, 1'b0);
    pulse_start(0, 1'b0);
    run_range(0, 16, 0, -1);
    repeat (3) @(negedge clk);
    chk("dut0_done_held", int'(bus0.o_done), 1);

    // stuck-at-0: only 0000 passes
    push_exp(0, 1, 15, 4'b0001, 1'b1, 1'b0);
    pulse_start(0, 1'b0);
    run_range(0, 16, 1, -1);
    repeat (3) @(negedge clk);

    // stuck-at-1: only 0000 fails, first failing vector is 0000
    push_exp(0, 15, 1, 4'b0000, 1'b1, 1'b0);
    pulse_start(0, 1'b0);
    run_range(0, 16, 2, -1);
    repeat (3) @(negedge clk);

    // partial run with failures and a stray, then reset mid-run
    pulse_start(0, 1'b0);
    apply_vec(0, 4'b0000, 1'b0, 1'b0);
    apply_vec(0, 4'b0010, 1'b0, 1'b1);
    apply_vec(0, 4'b0011, 1'b0, 1'b0);
    @(negedge clk);
    chk("pre_reset_fail", int'(bus0.o_fail_cnt), 2);
    chk("pre_reset_proto", int'(bus0.o_proto_err), 1);
    rst_n0 = 1'b0;
    @(negedge clk);
    chk_all_zero("midrun_reset");
    rst_n0 = 1'b1;
    push_exp(0, 16, 0, 4'b0000, 1'b0, 1'b0);
    pulse_start(0, 1'b0);
    run_range(0, 16, 0, -1);
    repeat (3) @(negedge clk);

    // stray vec_valid during settle: flagged, vector count unaffected
    push_exp(0, 16, 0, 4'b0000, 1'b0, 1'b1);
    pulse_start(0, 1'b0);
    run_range(0, 16, 0, 5);
    repeat (3) @(negedge clk);

    // start together with vec_valid while armed: clears, no capture, no error
    pulse_start(0, 1'b0);
    apply_vec(0, 4'b0001, 1'b0, 1'b1);
    apply_vec(0, 4'b0010, 1'b1, 1'b0);
    @(negedge clk);
    pulse_start(0, 1'b1);
    chk("start_vv_pass", int'(bus0.o_pass_cnt), 0);
    chk("start_vv_fail", int'(bus0.o_fail_cnt), 0);
    chk("start_vv_proto", int'(bus0.o_proto_err), 0);
    chk("start_vv_fail_seen", int'(bus0.o_fail_seen), 0);
    chk("start_vv_busy", int'(bus0.o_busy), 1);
    push_exp(0, 16, 0, 4'b0000, 1'b0, 1'b0);
    run_range(0, 16, 0, -1);

    for (int i = 0; i < 50 && sb_q.size() != 0; i++) @(negedge clk);
    chk("sb_drained", sb_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
